// File: rtl/demux1_2_fifo.sv
// demux1_2_fifo
//   Steers a registered word from the mux stage into one of two lanes, each
//   backed by a DEPTH-entry show-ahead FIFO with a valid/ready handshake.
//   Upstream is stalled by deasserting ready_out.
//   Optional build macro: DEMUX_STATS_EN adds the saturating push counters cnt0/cnt1.
// Ports
//   clk, reset_L           clock, asynchronous active-low reset
//   data_in/valid_in       word and qualifier from the mux stage
//   selector               destination lane (0 -> lane0, 1 -> lane1)
//   ready_out              selected lane is not full (combinational)
//   data_outL/valid_outL   registered head word / non-empty flag of lane L
//   ready_inL              lane L consumer takes the head word
//   fillL                  lane L occupancy, 0..DEPTH
//   cnt0/cnt1              (DEMUX_STATS_EN only) words accepted per lane
module demux1_2_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             selector,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out0,
  output logic             valid_out0,
  input  logic             ready_in0,
  output logic [WIDTH-1:0] data_out1,
  output logic             valid_out1,
  input  logic             ready_in1,
  output logic [AW:0]      fill0,
  output logic [AW:0]      fill1
`ifdef DEMUX_STATS_EN
  ,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
`endif
);

  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q  [2][DEPTH];
  logic [AW-1:0]    wr_q   [2];
  logic [AW-1:0]    wr_d   [2];
  logic [AW-1:0]    rd_q   [2];
  logic [AW-1:0]    rd_d   [2];
  logic [AW:0]      fill_q [2];
  logic [AW:0]      fill_d [2];
  logic [WIDTH-1:0] head_q [2];
  logic [WIDTH-1:0] head_d [2];
  logic [1:0]       valid_q, valid_d;
  logic [1:0]       push, pop, full, ready_in;

  always_comb begin
    ready_in = {ready_in1, ready_in0};
    for (int l = 0; l < 2; l++) begin
      full[l] = (fill_q[l] == FullCnt);
    end
    // No bypass: a pop in the same cycle does not free a slot for this push.
    ready_out = ~full[selector];
    push[0]   = valid_in & ready_out & ~selector;
    push[1]   = valid_in & ready_out & selector;
    pop       = valid_q & ready_in;

    for (int l = 0; l < 2; l++) begin
      wr_d[l]   = push[l] ? wr_q[l] + AW'(1) : wr_q[l];
      rd_d[l]   = pop[l]  ? rd_q[l] + AW'(1) : rd_q[l];
      fill_d[l] = fill_q[l];
      if (push[l] && !pop[l]) begin
        fill_d[l] = fill_q[l] + (AW+1)'(1);
      end else if (!push[l] && pop[l]) begin
        fill_d[l] = fill_q[l] - (AW+1)'(1);
      end
      valid_d[l] = (fill_d[l] != '0);
      // Head register is precomputed so data_out is a flop; when the slot that
      // becomes head is the one being written now, take data_in directly.
      if (!valid_d[l]) begin
        head_d[l] = '0;
      end else if (push[l] && (rd_d[l] == wr_q[l])) begin
        head_d[l] = data_in;
      end else begin
        head_d[l] = mem_q[l][rd_d[l]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int l = 0; l < 2; l++) begin
        wr_q[l]   <= '0;
        rd_q[l]   <= '0;
        fill_q[l] <= '0;
        head_q[l] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        wr_q[l]   <= wr_d[l];
        rd_q[l]   <= rd_d[l];
        fill_q[l] <= fill_d[l];
        head_q[l] <= head_d[l];
      end
      valid_q <= valid_d;
    end
  end

  // Storage needs no reset: contents are unreachable until rewritten.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (push[l]) begin
        mem_q[l][wr_q[l]] <= data_in;
      end
    end
  end

  assign data_out0  = head_q[0];
  assign data_out1  = head_q[1];
  assign valid_out0 = valid_q[0];
  assign valid_out1 = valid_q[1];
  assign fill0      = fill_q[0];
  assign fill1      = fill_q[1];

`ifdef DEMUX_STATS_EN
  logic [7:0] cnt_q [2];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (push[l] && (cnt_q[l] != 8'hFF)) begin
          cnt_q[l] <= cnt_q[l] + 8'd1;
        end
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
`endif

endmodule
